// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_BEATS  = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter serialising 32-bit words over a byte port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int BEATS  = DEFAULT_BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BW-1:0]     r_beat;
  logic              r_gnt;
  logic              r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_wdata;
  logic [23:0]       r_asm;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_d_rdata;

  logic              w_start;
  logic              w_gnt_d;
  logic              w_last_beat;
  logic              w_xfer;
  logic              w_done;
  logic [31:0]       w_asm_nxt;
  logic [7:0]        w_wbyte;

  assign w_start     = if_req | d_req;
  // Data wins a tie only when fetch held the previous grant.
  assign w_gnt_d     = d_req & (~if_req | (r_last == REQ_IF));
  assign w_last_beat = (r_beat == BW'(BEATS - 1));
  assign w_asm_nxt   = {r_asm, mem_rdata};
  assign w_wbyte     = 8'(r_wdata >> (8 * (BEATS - 1 - int'(r_beat))));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = XFER;
      XFER:    if (w_last_beat) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_beat     <= '0;
      r_gnt      <= REQ_IF;
      r_last     <= REQ_IF;
      r_we       <= 1'b0;
      r_base     <= '0;
      r_wdata    <= '0;
      r_asm      <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_gnt   <= w_gnt_d ? REQ_D : REQ_IF;
            r_last  <= w_gnt_d ? REQ_D : REQ_IF;
            r_base  <= w_gnt_d ? d_addr : if_addr;
            r_we    <= w_gnt_d & d_we;
            r_wdata <= w_gnt_d ? d_wdata : '0;
            r_beat  <= '0;
          end
        end
        XFER: begin
          r_asm  <= w_asm_nxt[23:0];
          r_beat <= w_last_beat ? '0 : r_beat + BW'(1);
          // The completed word lands in the delivery register as DONE begins.
          if (w_last_beat && !r_we) begin
            if (r_gnt == REQ_D) r_d_rdata  <= w_asm_nxt;
            else                r_if_rdata <= w_asm_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced quiet while rst is high so an aborted write stops at once.
  assign w_xfer    = (r_state == XFER) & ~rst;
  assign w_done    = (r_state == DONE) & ~rst;
  assign mem_addr  = w_xfer ? r_base + ADDR_W'(r_beat) : '0;
  assign mem_we    = w_xfer & r_we;
  assign mem_wdata = (w_xfer & r_we) ? w_wbyte : '0;
  assign if_ack    = w_done & (r_gnt == REQ_IF);
  assign d_ack     = w_done & (r_gnt == REQ_D);
  assign busy      = (r_state != IDLE) & ~rst;
  assign if_rdata  = rst ? '0 : r_if_rdata;
  assign d_rdata   = rst ? '0 : r_d_rdata;

endmodule
